// File: rtl/seed_if.sv
// seed_if: seed switches, buttons and engine handshake for seed_ctrl.
// master = sequencer side, slave = board/engine side.
interface seed_if #(
  parameter int GEN_W = 16
);
  logic [3:0]       key;
  logic             key_valid;
  logic             btn_start;
  logic             btn_pause;
  logic             load_ack;
  logic             step_ack;
  logic [1:0]       seed_sel;
  logic             load_req;
  logic             step_req;
  logic             running;
  logic [1:0]       status;
  logic [GEN_W-1:0] gen_count;

  modport master (
    input  key, key_valid, btn_start, btn_pause,
    input  load_ack, step_ack,
    output seed_sel, load_req, step_req,
    output running, status, gen_count
  );

  modport slave (
    output key, key_valid, btn_start, btn_pause,
    output load_ack, step_ack,
    input  seed_sel, load_req, step_req,
    input  running, status, gen_count
  );
endinterface

// File: rtl/seed_ctrl.sv
// seed_ctrl: Game of Life seed selection, load and step pacing sequencer.
// Optional macro GOL_GEN_LIMIT_EN pauses the run once MAX_GEN is reached.
module seed_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 25000000,
  parameter int GEN_W           = 16,
  parameter int MAX_GEN         = 1000
) (
  input logic    clk,
  input logic    reset,
  seed_if.master bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TK_W = $clog2(TICK_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);
`ifdef GOL_GEN_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_db;
  logic [1:0]       r_press;
  logic [DB_W-1:0]  r_db_cnt [2];
  logic [3:0]       r_key_q;
  logic [DB_W-1:0]  r_key_cnt;
  logic [TK_W-1:0]  r_tick;
  logic             r_pause_pend;
  logic             r_reseed_pend;
  logic [1:0]       r_seed_sel;
  logic             r_load_req;
  logic             r_step_req;
  logic             r_running;
  logic [GEN_W-1:0] r_gen;

  logic       w_start;
  logic       w_pause;
  logic       w_pause_any;
  logic       w_reseed_any;
  logic       w_tick_last;
  logic       w_at_limit;
  logic       w_key_onehot;
  logic       w_key_stable;
  logic [1:0] w_seed_idx;

  assign bus.seed_sel  = r_seed_sel;
  assign bus.load_req  = r_load_req;
  assign bus.step_req  = r_step_req;
  assign bus.running   = r_running;
  assign bus.status    = r_state;
  assign bus.gen_count = r_gen;

  // bit 0 = start, bit 1 = pause
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_press <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= {bus.btn_pause, bus.btn_start};
      r_sync2 <= r_sync1;
      r_press <= '0;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_db[i]     <= r_sync2[i];
          r_press[i]  <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_q   <= '0;
      r_key_cnt <= '0;
    end else begin
      r_key_q <= bus.key;
      if (!bus.key_valid || bus.key != r_key_q)
        r_key_cnt <= '0;
      else if (r_key_cnt != DB_FULL)
        r_key_cnt <= r_key_cnt + 1'b1;
    end
  end

  assign w_key_onehot = (bus.key != 4'd0) &&
                        ((bus.key & (bus.key - 4'd1)) == 4'd0);
  assign w_key_stable = bus.key_valid && w_key_onehot &&
                        (bus.key == r_key_q) &&
                        (r_key_cnt == DB_FULL);

  always_comb begin
    w_seed_idx = 2'd0;
    case (bus.key)
      4'b0010: w_seed_idx = 2'd1;
      4'b0100: w_seed_idx = 2'd2;
      4'b1000: w_seed_idx = 2'd3;
      default: w_seed_idx = 2'd0;
    endcase
  end

  assign w_start      = r_press[0];
  assign w_pause      = r_press[1];
  assign w_pause_any  = r_pause_pend | w_pause;
  assign w_reseed_any = r_reseed_pend | w_start;
  assign w_tick_last  = (r_tick == TK_LAST);
  assign w_at_limit   = LIMIT_EN && (r_gen == GEN_W'(MAX_GEN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_tick        <= '0;
      r_pause_pend  <= 1'b0;
      r_reseed_pend <= 1'b0;
      r_seed_sel    <= '0;
      r_load_req    <= 1'b0;
      r_step_req    <= 1'b0;
      r_running     <= 1'b0;
      r_gen         <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start && w_key_stable) begin
            r_seed_sel <= w_seed_idx;
            r_load_req <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.load_ack) begin
            r_load_req    <= 1'b0;
            r_gen         <= '0;
            r_tick        <= '0;
            r_pause_pend  <= 1'b0;
            r_reseed_pend <= 1'b0;
            r_running     <= 1'b1;
            r_state       <= S_RUN;
          end
        end
        S_RUN: begin
          r_tick <= w_tick_last ? '0 : r_tick + 1'b1;
          // presses wait for the outstanding step to finish
          if (r_step_req) begin
            r_pause_pend  <= w_pause_any;
            r_reseed_pend <= w_reseed_any;
            if (bus.step_ack) begin
              r_step_req <= 1'b0;
              r_gen      <= r_gen + 1'b1;
            end
          end else if (w_pause_any) begin
            r_pause_pend  <= 1'b0;
            r_reseed_pend <= 1'b0;
            r_running     <= 1'b0;
            r_state       <= S_PAUSE;
          end else if (w_reseed_any) begin
            r_reseed_pend <= 1'b0;
            r_running     <= 1'b0;
            r_state       <= S_IDLE;
          end else if (w_at_limit) begin
            r_running <= 1'b0;
            r_state   <= S_PAUSE;
          end else if (w_tick_last) begin
            r_step_req <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (w_start) begin
            r_state <= S_IDLE;
          end else if (w_pause && !w_at_limit) begin
            r_tick    <= '0;
            r_running <= 1'b1;
            r_state   <= S_RUN;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seed_ctrl.sv
// tb_seed_ctrl: directed plus randomized checks of seed_ctrl
// against a generation/timing model built from the block's rules.
module tb_seed_ctrl;
  localparam int DB = 4;
  localparam int TK = 8;
  localparam int GW = 16;
  localparam int MG = 3;
`ifdef GOL_GEN_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_gen = 0;
  int t_run = 0;
  int t_last = 0;
  int gap_next = 0;

  seed_if #(.GEN_W(GW)) bus ();

  seed_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_CYCLES(TK),
    .GEN_W(GW),
    .MAX_GEN(MG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark_run();
    t_run = cyc;
    t_last = cyc;
    gap_next = TK;
  endtask

  // hold buttons, answer any step request at once, wait for status
  task automatic press_until(input bit s, input bit p,
                             input logic [1:0] tgt, input string tag);
    int n;
    n = 0;
    bus.btn_start = s;
    bus.btn_pause = p;
    while (bus.status !== tgt && n < 60) begin
      if (n == 10) begin
        bus.btn_start = 1'b0;
        bus.btn_pause = 1'b0;
      end
      if (bus.step_req === 1'b1) begin
        bus.step_ack = 1'b1;
        step(1);
        bus.step_ack = 1'b0;
        exp_gen++;
      end else begin
        step(1);
      end
      n++;
    end
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    chk(tag, bus.status, tgt);
  endtask

  task automatic wait_req(output int t);
    int n;
    n = 0;
    while (bus.step_req !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    t = cyc;
    chk("req_seen", bus.step_req, 1);
  endtask

  task automatic ack_after(input int d);
    if (d > 1) step(d - 1);
    bus.step_ack = 1'b1;
    step(1);
    bus.step_ack = 1'b0;
    exp_gen++;
    chk("step_req_drop", bus.step_req, 0);
    chk("gen_count", bus.gen_count, exp_gen[GW-1:0]);
  endtask

  // a request every TK cycles unless one is still outstanding
  task automatic run_gens(input int ng, input int d_fixed);
    int t;
    int d;
    for (int g = 0; g < ng; g++) begin
      wait_req(t);
      chk("step_gap", t - t_last, gap_next);
      if (d_fixed > 0) d = d_fixed;
      else if ($urandom_range(0, 3) == 0) d = int'($urandom_range(8, 20));
      else d = int'($urandom_range(1, 7));
      ack_after(d);
      t_last = t;
      gap_next = TK * (d / TK + 1);
    end
  endtask

  task automatic do_load(input int k, input int ld);
    bus.key = 4'(1 << k);
    bus.key_valid = 1'b1;
    step(10);
    press_until(1'b1, 1'b0, 2'd1, "load_enter");
    chk("seed_sel", bus.seed_sel, k);
    chk("load_req_set", bus.load_req, 1);
    if (ld > 1) step(ld - 1);
    chk("load_hold", bus.status, 1);
    bus.load_ack = 1'b1;
    step(1);
    bus.load_ack = 1'b0;
    mark_run();
    exp_gen = 0;
    chk("run_enter", bus.status, 2);
    chk("load_req_clr", bus.load_req, 0);
    chk("gen_clear", bus.gen_count, 0);
    chk("running", bus.running, 1);
  endtask

  initial begin
    int t;
    int k;
    int ng;
    int act;
    bit seen;
    bus.key = 4'd0;
    bus.key_valid = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    bus.load_ack = 1'b0;
    bus.step_ack = 1'b0;
    #2;
    chk("rst_status", bus.status, 0);
    chk("rst_load_req", bus.load_req, 0);
    chk("rst_step_req", bus.step_req, 0);
    chk("rst_gen", bus.gen_count, 0);
    chk("rst_running", bus.running, 0);
    step(2);
    reset = 1'b0;
    step(2);

    // invalid key combination never loads
    bus.key = 4'b0110;
    bus.key_valid = 1'b0;
    seen = 1'b0;
    bus.btn_start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) bus.btn_start = 1'b0;
      step(1);
      if (bus.load_req === 1'b1) seen = 1'b1;
    end
    chk("no_load_invalid", seen, 0);
    chk("idle_invalid", bus.status, 0);

    // bouncing key never becomes stable
    bus.key_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (i % 3 == 0) bus.key = 4'(1 << (i / 3 % 4));
      bus.btn_start = (i >= 5 && i < 15);
      step(1);
      if (bus.load_req === 1'b1) seen = 1'b1;
    end
    chk("no_load_bounce", seen, 0);
    bus.load_ack = 1'b1;
    step(1);
    bus.load_ack = 1'b0;
    chk("idle_load_ack", bus.status, 0);

    do_load(2, 3);
    run_gens(3, 2);
`ifdef GOL_GEN_LIMIT_EN
    step(1);
    chk("limit_pause", bus.status, 3);
    bus.btn_pause = 1'b1;
    step(10);
    bus.btn_pause = 1'b0;
    step(10);
    chk("limit_hold", bus.status, 3);
    press_until(1'b1, 1'b0, 2'd0, "limit_reseed");
`else
    run_gens(1, 20);
    chk("no_limit_run", bus.running, 1);
    wait_req(t);
    chk("gap_after_drop", t - t_last, gap_next);
    bus.btn_pause = 1'b1;
    step(20);
    chk("pend_run", bus.status, 2);
    chk("pend_req", bus.step_req, 1);
    bus.btn_pause = 1'b0;
    step(10);
    ack_after(1);
    chk("pend_still_run", bus.status, 2);
    step(1);
    chk("pause_enter", bus.status, 3);
    chk("pause_running", bus.running, 0);
    step(10);
    bus.step_ack = 1'b1;
    step(1);
    bus.step_ack = 1'b0;
    step(10);
    chk("pause_gen_frozen", bus.gen_count, exp_gen[GW-1:0]);
    chk("pause_no_req", bus.step_req, 0);
    press_until(1'b0, 1'b1, 2'd2, "resume");
    mark_run();
    run_gens(1, 1);
    step(2);
    press_until(1'b0, 1'b1, 2'd3, "pause_again");
    step(10);
    press_until(1'b1, 1'b0, 2'd0, "pause_start_idle");
    chk("idle_seed_hold", bus.seed_sel, 2);
    chk("idle_gen_hold", bus.gen_count, exp_gen[GW-1:0]);
`endif

    for (int r = 0; r < 6; r++) begin
      k = int'($urandom_range(0, 3));
      do_load(k, int'($urandom_range(1, 5)));
      bus.key = 4'(1 << $urandom_range(0, 3));
      ng = LIM ? 1 : int'($urandom_range(1, 3));
      run_gens(ng, 0);
      act = int'($urandom_range(0, 2));
      if (act == 0) begin
        press_until(1'b0, 1'b1, 2'd3, "rnd_pause");
        step(10);
        chk("rnd_frozen", bus.gen_count, exp_gen[GW-1:0]);
        press_until(1'b0, 1'b1, 2'd2, "rnd_resume");
        mark_run();
        run_gens(1, 1);
        press_until(1'b1, 1'b0, 2'd0, "rnd_reseed");
      end else if (act == 1) begin
        press_until(1'b1, 1'b0, 2'd0, "rnd_reseed");
      end else begin
        press_until(1'b1, 1'b1, 2'd3, "rnd_both_pause");
        step(10);
        chk("rnd_both_stay", bus.status, 3);
        press_until(1'b1, 1'b0, 2'd0, "rnd_pause_start");
      end
      chk("rnd_seed_hold", bus.seed_sel, k);
      chk("rnd_gen_hold", bus.gen_count, exp_gen[GW-1:0]);
      chk("rnd_idle_run", bus.running, 0);
    end

    // asynchronous reset with a step outstanding
    do_load(1, 2);
    wait_req(t);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_status", bus.status, 0);
    chk("arst_step_req", bus.step_req, 0);
    chk("arst_gen", bus.gen_count, 0);
    chk("arst_running", bus.running, 0);
    chk("arst_seed", bus.seed_sel, 0);
    step(1);
    reset = 1'b0;
    step(3);
    chk("arst_idle", bus.status, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seed_ctrl.md
Name: seed_ctrl

Overview:
Sequencer for Game of Life seed selection and run control. It qualifies the one-hot 4-bit seed switches and their validity flag, debounces the start and pause buttons, and issues a seed-load request to the board engine. It then paces generation steps with a timer using a req/ack handshake, and supports pause, resume and reseed.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles an input must be stable before it is accepted (10 ms at 100 MHz)
TICK_CYCLES, 25000000, cycles between generation step requests
GEN_W, 16, generation counter width
MAX_GEN, 1000, generation limit (used only with GOL_GEN_LIMIT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
key  in  4  seed switches, one-hot when valid
key_valid  in  1  key-validity flag from the seed-switch decoder
btn_start  in  1  raw start/reseed button, asynchronous
btn_pause  in  1  raw pause/resume button, asynchronous
load_ack  in  1  board engine has loaded the seed
step_ack  in  1  board engine has computed a generation
seed_sel  out  2  latched seed index
load_req  out  1  seed-load request, level held until ack
step_req  out  1  generation step request, level held until ack
running  out  1  high in RUN
status  out  2  state code: IDLE=0, LOAD=1, RUN=2, PAUSE=3
gen_count  out  GEN_W  generations completed since the last load

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; all counters, synchronizers and pending flags 0.
- Buttons: 2-flop synchronizer, then a debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive identical samples. A rising edge of the debounced level produces a one-cycle press pulse.
- key_stable: key_valid=1 and key unchanged for DEBOUNCE_CYCLES cycles. Any change of key clears the counter.
- IDLE: start press with key_stable → latch seed_sel (0001→0, 0010→1, 0100→2, 1000→3), load_req=1, go to LOAD. Start press without key_stable is ignored. Pause press is ignored.
- LOAD: load_req stays high until load_ack is sampled high. On that edge: load_req=0, gen_count=0, tick counter=0, go to RUN. Button presses are ignored in LOAD.
- RUN: tick counter counts 0..TICK_CYCLES-1 and wraps.
  - At terminal count with step_req=0: set step_req=1.
  - At terminal count with step_req=1: the tick is dropped, not queued.
  - step_ack sampled high while step_req=1 → step_req=0 next edge, gen_count+1 (wraps modulo 2^GEN_W).
- Pause or start press in RUN sets pause_pend or reseed_pend. Both take effect on the first cycle with step_req=0.
  - Pause → PAUSE.
  - Reseed → IDLE.
  - If both are pending, pause has priority; reseed_pend is cleared.
- PAUSE: tick counter holds; step_req=0.
  - Pause press → RUN with tick counter cleared.
  - Start press → IDLE.
  - Simultaneous presses → IDLE.
- seed_sel and gen_count hold in PAUSE and IDLE until the next load. Key changes outside IDLE have no effect.
- running = (state==RUN). status is registered with the state.
- Acks arriving while no request is outstanding are ignored.

Optional Feature:
GOL_GEN_LIMIT_EN
- Defined: when a step_ack brings gen_count to MAX_GEN, the block enters PAUSE on the next edge. Pause press from PAUSE is ignored while gen_count==MAX_GEN; only a start press (reseed) leaves.
- Undefined: no limit; gen_count wraps and RUN continues indefinitely.

Test Plan:
(Sim parameters: DEBOUNCE_CYCLES=4, TICK_CYCLES=8.)
1. Reset mid-RUN with step_req=1 → same cycle: status=0, step_req=0, gen_count=0, running=0.
2. key=0100, key_valid=1 held 6 cycles, then start press → seed_sel=2, load_req=1, status=1. load_ack 3 cycles later → load_req=0, status=2.
3. key=0110 (key_valid=0), start press → remains IDLE, load_req never asserted. Key bouncing every 3 cycles → no load.
4. In RUN with step_ack returned 2 cycles after each req → step_req every 8 cycles; gen_count 0→1→2→3 after 3 acks. Withholding ack for 20 cycles → single outstanding req, gen_count +1 only.
5. Pause press while step_req=1 → state stays RUN until ack, then status=3, gen_count frozen. Second pause press → RUN, next req 8 cycles later. Start press in PAUSE → status=0.
6. With GOL_GEN_LIMIT_EN, MAX_GEN=3 → after 3rd ack status=3; pause press ignored; start press → IDLE.
